apb_periph_hub: RTL and testbench



---
 rtl/apb_periph_hub.sv | 154 +++++++++++++++
 tb/tb_apb_periph_hub.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/apb_periph_hub.sv
// apb_periph_hub: APB hub with runtime address map, decode-miss errors and fault capture.
// Define APB_HUB_TIMEOUT_EN to add the watchdog that aborts stalled transfers.
module apb_periph_hub #(
    parameter int NumPerip      = 4,
    parameter int AddrWidth     = 32,
    parameter int DataWidth     = 32,
    parameter int TimeoutCycles = 64
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          s_psel_i,
    input  logic                          s_penable_i,
    input  logic                          s_pwrite_i,
    input  logic [AddrWidth-1:0]          s_paddr_i,
    input  logic [DataWidth-1:0]          s_pwdata_i,
    output logic [DataWidth-1:0]          s_prdata_o,
    output logic                          s_pready_o,
    output logic                          s_pslverr_o,
    input  logic [NumPerip*AddrWidth-1:0] map_base_i,
    input  logic [NumPerip*AddrWidth-1:0] map_last_i,
    output logic [NumPerip-1:0]           m_psel_o,
    output logic [NumPerip-1:0]           m_penable_o,
    output logic [NumPerip-1:0]           m_pwrite_o,
    output logic [AddrWidth-1:0]          m_paddr_o,
    output logic [DataWidth-1:0]          m_pwdata_o,
    input  logic [NumPerip*DataWidth-1:0] m_prdata_i,
    input  logic [NumPerip-1:0]           m_pready_i,
    input  logic [NumPerip-1:0]           m_pslverr_i,
    output logic                          err_valid_o,
    output logic [1:0]                    err_cause_o,
    output logic [AddrWidth-1:0]          err_addr_o,
    output logic                          err_irq_o,
    input  logic                          err_clr_i
);
    localparam int SelW = NumPerip > 1 ? $clog2(NumPerip) : 1;

    if (NumPerip < 1 || NumPerip > 16 || TimeoutCycles < 2) begin : g_param_err
        $error("apb_periph_hub: illegal parameter value");
    end

`ifdef APB_HUB_TIMEOUT_EN
    typedef enum logic [1:0] {IDLE, ACCESS, ABORT} state_e;
    localparam int WaitW = $clog2(TimeoutCycles);
    logic [WaitW-1:0] wait_q;
`else
    typedef enum logic [1:0] {IDLE, ACCESS} state_e;
`endif

    state_e                state_q;
    logic [SelW-1:0]       sel_q, sel_d;
    logic                  hit_q, hit_d;
    logic                  en_q;
    logic [AddrWidth-1:0]  addr_q;
    logic                  abort, fault;

    assign m_paddr_o  = s_paddr_i;
    assign m_pwdata_o = s_pwdata_i;
    assign m_pwrite_o = {NumPerip{s_pwrite_i}};

    // Scan downwards so the lowest matching port is the last one written.
    always_comb begin
        hit_d = 1'b0;
        sel_d = '0;
        for (int k = NumPerip - 1; k >= 0; k--) begin
            if (map_base_i[k*AddrWidth +: AddrWidth] <= s_paddr_i &&
                s_paddr_i < map_last_i[k*AddrWidth +: AddrWidth]) begin
                hit_d = 1'b1;
                sel_d = SelW'(k);
            end
        end
    end

`ifdef APB_HUB_TIMEOUT_EN
    assign abort = state_q == ABORT;
`else
    assign abort = 1'b0;
`endif
    assign fault = abort || (state_q == ACCESS && s_psel_i && !hit_q);

    // First access cycle is the peripheral's setup phase (en_q low).
    always_comb begin
        m_psel_o    = '0;
        m_penable_o = '0;
        s_pready_o  = 1'b0;
        s_pslverr_o = 1'b0;
        s_prdata_o  = '0;
        if (state_q == ACCESS && hit_q) begin
            m_psel_o[sel_q]    = 1'b1;
            m_penable_o[sel_q] = en_q;
            if (en_q) begin
                s_pready_o  = m_pready_i[sel_q];
                s_pslverr_o = m_pslverr_i[sel_q];
                s_prdata_o  = m_prdata_i[sel_q*DataWidth +: DataWidth];
            end
        end else if (state_q == ACCESS || abort) begin
            s_pready_o  = 1'b1;
            s_pslverr_o = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            hit_q       <= 1'b0;
            en_q        <= 1'b0;
            addr_q      <= '0;
            err_valid_o <= 1'b0;
            err_cause_o <= 2'b00;
            err_addr_o  <= '0;
            err_irq_o   <= 1'b0;
`ifdef APB_HUB_TIMEOUT_EN
            wait_q      <= '0;
`endif
        end else begin
            err_irq_o <= fault;
            if (fault && (!err_valid_o || err_clr_i)) begin
                err_valid_o <= 1'b1;
                err_cause_o <= abort ? 2'b10 : 2'b01;
                err_addr_o  <= addr_q;
            end else if (err_clr_i) begin
                err_valid_o <= 1'b0;
                err_cause_o <= 2'b00;
                err_addr_o  <= '0;
            end
            case (state_q)
                IDLE: begin
                    if (s_psel_i && !s_penable_i) begin
                        state_q <= ACCESS;
                        sel_q   <= sel_d;
                        hit_q   <= hit_d;
                        addr_q  <= s_paddr_i;
                        en_q    <= 1'b0;
`ifdef APB_HUB_TIMEOUT_EN
                        wait_q  <= '0;
`endif
                    end
                end
                ACCESS: begin
                    if (!s_psel_i || s_pready_o) begin
                        state_q <= IDLE;
                    end else begin
                        en_q <= 1'b1;
`ifdef APB_HUB_TIMEOUT_EN
                        if (wait_q == WaitW'(TimeoutCycles - 1)) state_q <= ABORT;
                        else wait_q <= wait_q + 1'b1;
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_periph_hub.sv
// tb_apb_periph_hub: directed and randomized APB transfers checked against a
// transaction-level model of decode, latency and error capture.
module tb_apb_periph_hub;
    localparam int NP = 4;
    localparam int T  = 8;
`ifdef APB_HUB_TIMEOUT_EN
    localparam bit ToEn = 1'b1;
`else
    localparam bit ToEn = 1'b0;
`endif

    logic clk_i = 1'b0, rst_ni = 1'b0;
    logic s_psel_i = 0, s_penable_i = 0, s_pwrite_i = 0;
    logic [31:0] s_paddr_i = '0, s_pwdata_i = '0, s_prdata_o;
    logic s_pready_o, s_pslverr_o;
    logic [NP*32-1:0] map_base_i, map_last_i, m_prdata_i;
    logic [NP-1:0] m_psel_o, m_penable_o, m_pwrite_o, m_pready_i, m_pslverr_i;
    logic [31:0] m_paddr_o, m_pwdata_o, err_addr_o;
    logic err_valid_o, err_irq_o, err_clr_i = 0;
    logic [1:0] err_cause_o;

    apb_periph_hub #(.NumPerip(NP), .AddrWidth(32), .DataWidth(32), .TimeoutCycles(T)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .s_psel_i(s_psel_i), .s_penable_i(s_penable_i), .s_pwrite_i(s_pwrite_i),
        .s_paddr_i(s_paddr_i), .s_pwdata_i(s_pwdata_i), .s_prdata_o(s_prdata_o),
        .s_pready_o(s_pready_o), .s_pslverr_o(s_pslverr_o),
        .map_base_i(map_base_i), .map_last_i(map_last_i),
        .m_psel_o(m_psel_o), .m_penable_o(m_penable_o), .m_pwrite_o(m_pwrite_o),
        .m_paddr_o(m_paddr_o), .m_pwdata_o(m_pwdata_o), .m_prdata_i(m_prdata_i),
        .m_pready_i(m_pready_i), .m_pslverr_i(m_pslverr_i),
        .err_valid_o(err_valid_o), .err_cause_o(err_cause_o), .err_addr_o(err_addr_o),
        .err_irq_o(err_irq_o), .err_clr_i(err_clr_i)
    );

    always #5 clk_i = ~clk_i;

    // Peripheral models: each port answers after waits[k] enable cycles.
    logic [31:0] base[NP], last[NP], pdat[NP];
    logic        perr[NP];
    int          waits[NP], cnt[NP];
    int          log_port;
    logic [31:0] log_wdata;
    logic        log_write;

    always_comb begin
        for (int k = 0; k < NP; k++) begin
            map_base_i[k*32 +: 32] = base[k];
            map_last_i[k*32 +: 32] = last[k];
            m_prdata_i[k*32 +: 32] = pdat[k];
            m_pslverr_i[k]         = perr[k];
            m_pready_i[k]          = m_psel_o[k] && m_penable_o[k] && cnt[k] >= waits[k];
        end
    end

    always @(posedge clk_i) begin
        for (int k = 0; k < NP; k++) begin
            cnt[k] <= (m_psel_o[k] && m_penable_o[k] && !m_pready_i[k]) ? cnt[k] + 1 : 0;
            if (m_psel_o[k] && m_penable_o[k] && m_pready_i[k]) begin
                log_port  <= k;
                log_wdata <= m_pwdata_o;
                log_write <= m_pwrite_o[k];
            end
        end
    end

    int nvec = 0, nfail = 0;
    logic        mv;
    logic [1:0]  mc;
    logic [31:0] ma;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int decode(input logic [31:0] a);
        for (int k = 0; k < NP; k++) if (base[k] <= a && a < last[k]) return k;
        return -1;
    endfunction

    task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] wd, input logic clr,
                        output int cyc, output logic [31:0] rd, output logic se, output logic [NP-1:0] seen);
        bit done = 0;
        @(posedge clk_i); #1;
        s_psel_i = 1; s_penable_i = 0; s_paddr_i = a; s_pwrite_i = w; s_pwdata_i = wd;
        seen = '0; rd = 'x; se = 'x; cyc = 0;
        @(posedge clk_i); #1;
        s_penable_i = 1; err_clr_i = clr;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk_i);
            cyc++;
            seen |= m_psel_o;
            if (s_pready_o) begin
                rd = s_prdata_o; se = s_pslverr_o; done = 1;
            end
        end
        if (!done) cyc = -1;
        @(posedge clk_i); #1;
        s_psel_i = 0; s_penable_i = 0; err_clr_i = 0;
    endtask

    // One transfer checked against the model: latency, data, select, error registers.
    task automatic run(input string tag, input logic [31:0] a, input logic w, input logic [31:0] wd, input logic clr);
        int p, cyc, ecyc;
        logic [31:0] rd, erd;
        logic se, ese, to, f;
        logic [NP-1:0] seen;
        p   = decode(a);
        to  = ToEn && p >= 0 && waits[p] + 2 > T;
        f   = p < 0 || to;
        ecyc = p < 0 ? 1 : (to ? T + 1 : waits[p] + 2);
        erd = (p < 0 || to) ? 32'h0 : pdat[p];
        ese = (p < 0 || to) ? 1'b1 : perr[p];
        xfer(a, w, wd, clr, cyc, rd, se, seen);
        chk({tag, ".cycles"}, 64'(cyc), 64'(ecyc));
        chk({tag, ".prdata"}, 64'(rd), 64'(erd));
        chk({tag, ".pslverr"}, 64'(se), 64'(ese));
        chk({tag, ".psel_seen"}, 64'(seen), p < 0 ? 64'h0 : 64'(1 << p));
        if (p >= 0 && !to) begin
            chk({tag, ".port"}, 64'(log_port), 64'(p));
            chk({tag, ".pwrite"}, 64'(log_write), 64'(w));
            if (w) chk({tag, ".pwdata"}, 64'(log_wdata), 64'(wd));
        end
        if (f && (!mv || clr)) begin
            mv = 1; mc = to ? 2'b10 : 2'b01; ma = a;
        end else if (clr) begin
            mv = 0; mc = 0; ma = 0;
        end
        @(negedge clk_i);
        chk({tag, ".irq"}, 64'(err_irq_o), 64'(f));
        chk({tag, ".err_valid"}, 64'(err_valid_o), 64'(mv));
        chk({tag, ".err_cause"}, 64'(err_cause_o), 64'(mc));
        chk({tag, ".err_addr"}, 64'(err_addr_o), 64'(ma));
        chk({tag, ".m_psel_idle"}, 64'(m_psel_o), 64'h0);
        @(negedge clk_i);
        chk({tag, ".irq_off"}, 64'(err_irq_o), 64'h0);
    endtask

    initial begin
        base = '{32'h1000, 32'h2000, 32'h0, 32'h3000};
        last = '{32'h2000, 32'h3000, 32'h0, 32'h3800};
        waits = '{0, 0, 0, 0};
        cnt = '{0, 0, 0, 0};
        perr = '{0, 0, 0, 0};
        for (int k = 0; k < NP; k++) pdat[k] = $urandom;
        mv = 0; mc = 0; ma = 0;
        repeat (3) @(negedge clk_i);
        chk("rst.pready", 64'(s_pready_o), 64'h0);
        chk("rst.pslverr", 64'(s_pslverr_o), 64'h0);
        chk("rst.prdata", 64'(s_prdata_o), 64'h0);
        chk("rst.m_psel", 64'({m_psel_o, m_penable_o}), 64'h0);
        chk("rst.err", 64'({err_valid_o, err_cause_o, err_irq_o, err_addr_o}), 64'h0);
        rst_ni = 1;
        repeat (2) @(negedge clk_i);

        run("wr_port1", 32'h2004, 1, 32'hDEADBEEF, 0);
        run("rd_port3", 32'h3010, 0, 32'h0, 0);
        run("miss_9000", 32'h9000, 0, 32'h0, 0);
        run("miss_A000", 32'hA000, 1, 32'h1234, 0);
        run("clr_miss_B000", 32'hB000, 0, 32'h0, 1);
        run("clr_hit", 32'h1000, 0, 32'h0, 1);
        run("edge_last", 32'h1FFF, 0, 32'h0, 0);
        run("edge_empty", 32'h0, 0, 32'h0, 0);
        waits[1] = 3; perr[1] = 1;
        run("wait3_err", 32'h2FFC, 0, 32'h0, 0);
        waits[1] = 0; perr[1] = 0;

`ifdef APB_HUB_TIMEOUT_EN
        waits[0] = T - 2;
        run("wait_at_limit", 32'h1100, 0, 32'h0, 0);
        waits[0] = 1000;
        run("timeout", 32'h1004, 0, 32'h0, 1);
        waits[0] = 0;
`endif

        base[2] = 32'h1800; last[2] = 32'h2800;
        run("overlap_1900", 32'h1900, 0, 32'h0, 0);
        run("overlap_2400", 32'h2400, 0, 32'h0, 0);

        // Manager drops psel mid-transfer: no fault, hub idles again.
        waits[3] = 5;
        @(posedge clk_i); #1;
        s_psel_i = 1; s_penable_i = 0; s_paddr_i = 32'h3100;
        @(posedge clk_i); #1;
        s_penable_i = 1;
        @(posedge clk_i); #1;
        s_psel_i = 0; s_penable_i = 0;
        repeat (2) @(negedge clk_i);
        chk("abandon.m_psel", 64'(m_psel_o), 64'h0);
        chk("abandon.irq", 64'(err_irq_o), 64'h0);
        chk("abandon.err_valid", 64'(err_valid_o), 64'(mv));
        waits[3] = 0;

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            for (int k = 0; k < NP; k++) begin
                waits[k] = $urandom_range(ToEn ? T : 3, 0);
                pdat[k]  = $urandom;
                perr[k]  = $urandom_range(1, 0);
            end
            a = $urandom_range(3, 0) == 0 ? $urandom : 32'($urandom_range(32'h3FFF, 32'h0));
            run("rand", a, 1'($urandom), $urandom, $urandom_range(4, 0) == 0);
        end

        // Asynchronous reset mid-transfer clears everything immediately.
        waits[1] = 10;
        @(posedge clk_i); #1;
        s_psel_i = 1; s_penable_i = 0; s_paddr_i = 32'h2000;
        @(posedge clk_i); #1;
        s_penable_i = 1;
        @(negedge clk_i); @(negedge clk_i);
        #2 rst_ni = 0;
        #1;
        chk("arst.m_psel", 64'(m_psel_o), 64'h0);
        chk("arst.pready", 64'(s_pready_o), 64'h0);
        chk("arst.err", 64'({err_valid_o, err_irq_o, err_cause_o}), 64'h0);
        s_psel_i = 0; s_penable_i = 0;
        @(negedge clk_i);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
